d7s_scan_ctrl: RTL
==================

D7S_SCAN_CTRL -- requirements
Module: d7s_scan_ctrl

Interface
REQ-001 SHALL have parameter DRIVE_CYC, default 1000, clock cycles each digit is driven (legal range >=2).
REQ-002 SHALL have parameter BLANK_CYC, default 4, all-off cycles before each digit (anti-ghosting, legal range >=1).
REQ-003 SHALL have port clk, input, 1, sole clock; all flops rising-edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, scan enable.
REQ-006 SHALL have port wr_valid, input, 1, digit write request.
REQ-007 SHALL have port wr_ready, output, 1, write accept; transfer occurs when wr_valid & wr_ready at a rising edge.
REQ-008 SHALL have port wr_addr, input, 2, digit index 0..2; 3 is accepted and discarded.
REQ-009 SHALL have port wr_data, input, 4, digit value.
REQ-010 SHALL have port transistor, output, 3, one-hot digit select, active high, bit i = digit i.
REQ-011 SHALL have port seg, output, 7, segments active high, bit0=a .. bit6=g.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse per completed 3-digit frame.

Function
REQ-013 SHALL implement FSM states IDLE, BLANK, DRIVE with one cycle counter and 2-bit digit index idx.
REQ-014 IDLE: transistor=0, seg=0, idx=0; en=1 -> BLANK next cycle.
REQ-015 BLANK: transistor=0, seg=0 for exactly BLANK_CYC cycles, then DRIVE.
REQ-016 DRIVE: transistor=one-hot(idx), seg=decode(shadow[idx]) for exactly DRIVE_CYC cycles, then BLANK with idx+1, wrapping 2->0.
REQ-017 transistor and seg SHALL be registered; they change on the same edge as the state change they reflect.
REQ-018 en=0 sampled in any state -> IDLE next cycle, outputs off, idx=0, counter cleared; no frame_done.
REQ-019 Digits SHALL be double-buffered: accepted writes go to staging[wr_addr]; display reads shadow.
REQ-020 Frame commit: on the last DRIVE cycle of idx=2, shadow <= staging and frame_done=1 on the following cycle.
REQ-021 wr_ready SHALL be 0 only during the commit cycle, otherwise 1; a write held across commit is accepted the next cycle into the next frame.
REQ-022 In IDLE, shadow SHALL copy staging every cycle (write visible immediately on next enable).
REQ-023 Decode: 0..9 -> 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F; 10..15 -> 0x40 (dash).
REQ-024 Frame period SHALL be exactly 3*(BLANK_CYC+DRIVE_CYC) cycles while en stays 1.
REQ-025 At most one transistor bit SHALL be high in any cycle, and never in the cycle immediately after another digit was driven.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, idx=0, counter=0, staging=0, shadow=0, transistor=0, seg=0, frame_done=0, wr_ready=1.
REQ-027 Reset asserted mid-DRIVE SHALL turn outputs off without waiting for a clock edge; release resumes in IDLE.

Structure
REQ-028 Package d7s_pkg SHALL hold the state enum, NUM_DIGITS=3, and the 16-entry segment pattern constants.
REQ-029 Combinational sub-module d7s_seg_decode (4-bit in, 7-bit out) SHALL implement REQ-023.
REQ-030 The top-level wrapper SHALL drive uo_out[6:0]=seg, uio_out[7:5]=transistor, with uio_oe[7:5]=1.

Verification (DRIVE_CYC=8, BLANK_CYC=2)
REQ-031 Reset, en=1, no writes -> transistor sequence 0,0,001x8,0,0,010x8,0,0,100x8, seg=0x3F while driven, frame_done every 30 cycles.
REQ-032 Write 1,2,3 to addr 0,1,2 in IDLE, en=1 -> seg 0x06,0x5B,0x4F on digits 0,1,2 in first frame.
REQ-033 Mid-frame write 9 to addr 0 -> current frame unchanged; next frame digit 0 seg=0x6F.
REQ-034 wr_valid held high across commit -> wr_ready=0 exactly one cycle, write lands next cycle; addr 3 write changes nothing.
REQ-035 en dropped mid-DRIVE -> outputs 0 next cycle, idx=0; re-enable starts with BLANK then digit 0.
REQ-036 rst_n pulsed low mid-DRIVE between edges -> transistor=0 and seg=0 immediately; staging/shadow=0 after release.

Source files
------------

// File: rtl/d7s_pkg.sv
// Shared types and constants for the 3-digit multiplexed 7-segment scanner.
package d7s_pkg;

  localparam int unsigned NUM_DIGITS = 3;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StDrive
  } state_e;

  // Segment patterns, bit0 = a .. bit6 = g; codes 10..15 show a dash.
  localparam logic [15:0][6:0] SEG_PATTERNS = {
    7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40,
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [NUM_DIGITS-1:0] digit_sel(input logic [1:0] idx);
    logic [NUM_DIGITS-1:0] one;
    one = 1;
    return one << idx;
  endfunction

endpackage

// File: rtl/d7s_scan_ctrl_if.sv
// Digit write bus: valid/ready handshake carrying a digit index and a 4-bit value.
interface d7s_scan_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/d7s_seg_decode.sv
// Combinational hex-digit to 7-segment decode (0..9 digits, 10..15 dash).
module d7s_seg_decode
  import d7s_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_PATTERNS[digit_i];

endmodule

// File: rtl/tt_um_d7s_scan_ctrl.sv
// Pin-level wrapper: ui_in = {wr_data, wr_addr, wr_valid, en}; segments on uo_out, digit
// selects on uio_out[7:5], frame_done on uo_out[7].
module tt_um_d7s_scan_ctrl #(
  parameter int unsigned DRIVE_CYC = 1000,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  d7s_scan_ctrl_if bus ();

  logic [2:0] transistor;
  logic [6:0] seg;
  logic       frame_done;
  logic       unused;

  assign bus.wr_valid = ui_in[1];
  assign bus.wr_addr  = ui_in[3:2];
  assign bus.wr_data  = ui_in[7:4];

  d7s_scan_ctrl #(
    .DRIVE_CYC (DRIVE_CYC),
    .BLANK_CYC (BLANK_CYC)
  ) u_scan (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (ui_in[0]),
    .wr         (bus.slave),
    .transistor (transistor),
    .seg        (seg),
    .frame_done (frame_done)
  );

  assign uo_out  = {frame_done, seg};
  assign uio_out = {transistor, 5'b0};
  assign uio_oe  = 8'hE0;
  assign unused  = &{1'b0, ena, uio_in, bus.wr_ready};

endmodule

// File: rtl/d7s_scan_ctrl.sv
// Time-multiplexed 3-digit 7-segment scan controller with blanking between digits
// and double-buffered digit storage committed once per frame.
module d7s_scan_ctrl
  import d7s_pkg::*;
#(
  parameter int unsigned DRIVE_CYC = 1000,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  d7s_scan_ctrl_if.slave        wr,
  output logic [NUM_DIGITS-1:0] transistor,
  output logic [6:0]            seg,
  output logic                  frame_done
);

  localparam int unsigned CNT_MAX = (DRIVE_CYC > BLANK_CYC) ? DRIVE_CYC : BLANK_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYC - 1);
  localparam logic [1:0]       LAST_IDX   = 2'(NUM_DIGITS - 1);

  state_e                      state_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [1:0]                  idx_q;
  logic [NUM_DIGITS-1:0][3:0]  staging_q;
  logic [NUM_DIGITS-1:0][3:0]  shadow_q;
  logic [3:0]                  cur_digit;
  logic [6:0]                  cur_seg;
  logic                        frame_end;
  logic                        commit;
  logic                        wr_fire;

  // Last drive cycle of the final digit; writes stall here so staging is stable while copied.
  assign frame_end   = (state_q == StDrive) && (cnt_q == DRIVE_LAST) && (idx_q == LAST_IDX);
  assign commit      = en && frame_end;
  assign wr.wr_ready = !frame_end;
  assign wr_fire     = wr.wr_valid && wr.wr_ready;

  always_comb begin
    cur_digit = shadow_q[0];
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (idx_q == 2'(i)) cur_digit = shadow_q[i];
    end
  end

  d7s_seg_decode u_seg_decode (
    .digit_i (cur_digit),
    .seg_o   (cur_seg)
  );

  // Address 3 matches no digit, so such writes are accepted and dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging_q <= '0;
      shadow_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_fire && (wr.wr_addr == 2'(i))) staging_q[i] <= wr.wr_data;
      end
      if ((state_q == StIdle) || commit) shadow_q <= staging_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      transistor <= '0;
      seg        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!en) begin
        state_q    <= StIdle;
        cnt_q      <= '0;
        idx_q      <= '0;
        transistor <= '0;
        seg        <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StBlank;
            cnt_q   <= '0;
            idx_q   <= '0;
          end
          StBlank: begin
            if (cnt_q == BLANK_LAST) begin
              state_q    <= StDrive;
              cnt_q      <= '0;
              transistor <= digit_sel(idx_q);
              seg        <= cur_seg;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          StDrive: begin
            if (cnt_q == DRIVE_LAST) begin
              state_q    <= StBlank;
              cnt_q      <= '0;
              transistor <= '0;
              seg        <= '0;
              if (idx_q == LAST_IDX) begin
                idx_q      <= '0;
                frame_done <= 1'b1;
              end else begin
                idx_q <= idx_q + 2'd1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
